// File: rtl/demux_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin demux arbiter.
// Imported by the interface, the picker and the top.
package demux_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/demux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side drives requests; the slave side (arbiter) returns the grant.
interface demux_rr_arbiter_if;
    import demux_rr_arbiter_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] gnt_id;
    logic             busy;
    logic             timeout;

    modport master (output en, req, input gnt, gnt_id, busy, timeout);
    modport slave  (input en, req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/demux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning
// ptr, ptr+1, ... modulo N_REQ.
module rr_pick
    import demux_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk the offsets from far to near so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter with bounded tenure and a one-cycle release gap;
// gnt_id drives the select of a downstream 1-to-4 demux.
module demux_rr_arbiter
    import demux_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic               clk,
    input  logic               rst,
    demux_rr_arbiter_if.slave  arb
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    arb_state_t       state;
    logic [N_REQ-1:0] gnt_q;
    logic [SEL_W-1:0] gnt_id_q;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic             busy_q;
    logic             timeout_q;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    rr_pick u_pick (
        .req   (arb.req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb.en && pick_found) begin
                        state           <= ST_GRANT;
                        gnt_q           <= '0;
                        gnt_q[pick_idx] <= 1'b1;
                        gnt_id_q        <= pick_idx;
                        hold_cnt        <= 8'd1;
                        busy_q          <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // Only the owner's request bit matters while a tenure runs.
                    if (!arb.req[gnt_id_q] || hold_cnt == HOLD_LIM) begin
                        state     <= ST_GAP;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        hold_cnt  <= '0;
                        ptr       <= gnt_id_q + SEL_W'(1);
                        timeout_q <= arb.req[gnt_id_q];
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    gnt_q    <= '0;
                    busy_q   <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign arb.gnt     = gnt_q;
    assign arb.gnt_id  = gnt_id_q;
    assign arb.busy    = busy_q;
    assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 15 and 3) share stimulus; a
// tenure-level reference model predicts every cycle and a monitor compares.
module tb_demux_rr_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_rr_arbiter_if a15 ();
    demux_rr_arbiter_if a3 ();

    demux_rr_arbiter #(.MAX_HOLD(15)) dut15 (.clk(clk), .rst(rst), .arb(a15));
    demux_rr_arbiter #(.MAX_HOLD(3))  dut3  (.clk(clk), .rst(rst), .arb(a3));

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model: owner (-1 = none), cycles held, gap flag, next-scan start.
    int m_owner[2], m_held[2], m_ptr[2], m_last[2], lim[2];
    bit m_gap[2], m_to[2];
    bit prev_to[2];

    task automatic model_step(input int i, input bit r, input bit e, input logic [3:0] rq,
                              output exp_t x);
        m_to[i] = 1'b0;
        if (r) begin
            m_owner[i] = -1; m_held[i] = 0; m_ptr[i] = 0; m_last[i] = 0; m_gap[i] = 0;
        end else if (m_gap[i]) begin
            m_gap[i] = 0;
        end else if (m_owner[i] < 0) begin
            if (e) begin
                for (int k = 0; k < 4; k++) begin
                    int c;
                    c = (m_ptr[i] + k) % 4;
                    if (rq[c] && m_owner[i] < 0) begin
                        m_owner[i] = c; m_last[i] = c; m_held[i] = 1;
                    end
                end
            end
        end else if (!rq[m_owner[i]] || m_held[i] == lim[i]) begin
            m_to[i]    = rq[m_owner[i]];
            m_ptr[i]   = (m_owner[i] + 1) % 4;
            m_owner[i] = -1; m_held[i] = 0; m_gap[i] = 1;
        end else begin
            m_held[i]++;
        end
        x.gnt  = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0;
        x.id   = 2'(m_last[i]);
        x.busy = (m_owner[i] >= 0);
        x.to   = m_to[i];
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] rq);
        exp_t x;
        @(negedge clk);
        rst = r; a15.en = e; a15.req = rq; a3.en = e; a3.req = rq;
        model_step(0, r, e, rq, x); q0.push_back(x);
        model_step(1, r, e, rq, x); q1.push_back(x);
    endtask

    task automatic repeat_step(input int n, input bit r, input bit e, input logic [3:0] rq);
        for (int k = 0; k < n; k++) step(r, e, rq);
    endtask

    task automatic cmp(input string nm, input int i, input exp_t e, input exp_t a);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
                     nm, $time, a.gnt, a.id, a.busy, a.to, e.gnt, e.id, e.busy, e.to);
        end
        n_cmp++;
        if (!$onehot0(a.gnt) || a.busy !== (a.gnt != 4'b0) || (a.to && prev_to[i])) begin
            n_bad++;
            $display("FAIL %s_invariant @%0t: got gnt=%b busy=%b to=%b prev_to=%b, want onehot0 gnt, busy==|gnt, single-cycle to",
                     nm, $time, a.gnt, a.busy, a.to, prev_to[i]);
        end
        prev_to[i] = a.to;
    endtask

    always @(posedge clk) begin
        #1;
        if (q0.size() > 0) cmp("mh15", 0, q0.pop_front(), {a15.gnt, a15.gnt_id, a15.busy, a15.timeout});
        if (q1.size() > 0) cmp("mh3", 1, q1.pop_front(), {a3.gnt, a3.gnt_id, a3.busy, a3.timeout});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rq;
        bit e, r;
        lim[0] = 15; lim[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1; m_held[i] = 0; m_ptr[i] = 0; m_last[i] = 0;
            m_gap[i] = 0; m_to[i] = 0; prev_to[i] = 0;
        end
        a15.en = 1'b0; a15.req = '0; a3.en = 1'b0; a3.req = '0;

        // Grant 0, voluntary drop, pointer skips idle requester 1.
        repeat_step(2, 1, 1, 4'b0101);
        repeat_step(4, 0, 1, 4'b0101);
        repeat_step(4, 0, 1, 4'b0100);
        repeat_step(2, 0, 1, 4'b0000);
        // Continuous contention: forced rotation with timeouts.
        repeat_step(2, 1, 1, 4'b0000);
        repeat_step(40, 0, 1, 4'b1111);
        // Pointer wrap after requester 3 releases.
        repeat_step(1, 1, 1, 4'b0000);
        repeat_step(2, 0, 1, 4'b1000);
        repeat_step(2, 0, 1, 4'b0000);
        repeat_step(3, 0, 1, 4'b1001);
        repeat_step(2, 0, 1, 4'b0000);
        // Enable low: current tenure kept, next grant blocked.
        repeat_step(1, 1, 1, 4'b0000);
        repeat_step(2, 0, 1, 4'b0010);
        repeat_step(3, 0, 0, 4'b0010);
        repeat_step(1, 0, 0, 4'b0000);
        repeat_step(4, 0, 0, 4'b1111);
        repeat_step(3, 0, 1, 4'b1111);
        // Reset mid-tenure, then regrant.
        repeat_step(1, 1, 1, 4'b0000);
        repeat_step(6, 0, 1, 4'b1000);
        repeat_step(1, 1, 1, 4'b1000);
        repeat_step(3, 0, 1, 4'b1000);

        rq = 4'($urandom);
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            e = ($urandom_range(0, 9) < 8);
            r = ($urandom_range(0, 99) == 0);
            step(r, e, rq);
        end

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
